// File: rtl/joypad_mmr_ctrl.sv
// joypad_mmr_ctrl
// NES joypad front end. It synchronises and debounces the raw button pins,
// flags per-pad changes of the debounced levels, and implements the
// $4016/$4017 strobe register and the serial read ports.
//
// Bus handshake: wr_en and rd_en are single-cycle qualifiers with no
// back-pressure. A decoded read registers dout on the same edge and holds it
// until the next decoded read. When wr_en and rd_en are both high, the write
// executes and the read is dropped.
module joypad_mmr_ctrl #(
   parameter int          NUM_PADS    = 2,
   parameter int          BTN_W       = 8,
   parameter int          DEB_BITS    = 21,
   parameter int          SYNC_STAGES = 2,
   parameter logic [15:0] BASE_ADDR   = 16'h4016
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [NUM_PADS*BTN_W-1:0] pad_in,
   input  logic [15:0]               addr,
   input  logic                      wr_en,
   input  logic                      rd_en,
   input  logic [7:0]                din,
   output logic [7:0]                dout,
   output logic [NUM_PADS*BTN_W-1:0] pad_level,
   output logic [NUM_PADS-1:0]       change_pulse
);

   localparam int                N       = NUM_PADS * BTN_W;
   localparam logic [DEB_BITS-1:0] CNT_MAX = '1;

   // Synchroniser chain; the last stage feeds the debouncer.
   logic [N-1:0]          sync_q [SYNC_STAGES];
   logic [N-1:0]          synced;

   // Debounce state: one counter and one stable level per button bit.
   logic [DEB_BITS-1:0]   cnt_q  [N];
   logic [DEB_BITS-1:0]   cnt_d  [N];
   logic [N-1:0]          stable_q;
   logic [N-1:0]          stable_d;
   logic [NUM_PADS-1:0]   chg_d;

   // Register interface state.
   logic                  strobe_q;
   logic                  strobe_d;
   logic [BTN_W-1:0]      sh_q   [NUM_PADS];
   logic [BTN_W-1:0]      sh_d   [NUM_PADS];
   logic [7:0]            dout_d;
   logic [15:0]           offset;
   logic                  wr_strobe;
   logic                  rd_ok;

   // Only bit 0 of the write data controls the strobe.
   logic                  unused_din;
   assign unused_din = ^din[7:1];

   assign synced    = sync_q[SYNC_STAGES-1];
   assign pad_level = stable_q;
   assign offset    = addr - BASE_ADDR;
   assign wr_strobe = wr_en && (addr == BASE_ADDR);
   assign rd_ok     = rd_en && !wr_en;

   // Shift raw pins through the synchroniser flops.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
      end else begin
         sync_q[0] <= pad_in;
         for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
      end
   end

   // Per-bit debounce: a mismatch must persist for 2^DEB_BITS cycles to flip the level.
   always_comb begin
      stable_d = stable_q;
      for (int i = 0; i < N; i++) begin
         cnt_d[i] = '0;
         if (synced[i] != stable_q[i]) begin
            if (cnt_q[i] == CNT_MAX) begin
               stable_d[i] = synced[i];
            end else begin
               cnt_d[i] = cnt_q[i] + 1'b1;
            end
         end
      end
      for (int p = 0; p < NUM_PADS; p++) begin
         chg_d[p] = |(stable_d[p*BTN_W +: BTN_W] ^ stable_q[p*BTN_W +: BTN_W]);
      end
   end

   // Debounce registers; the change pulse lines up with the pad_level update.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < N; i++) cnt_q[i] <= '0;
         stable_q     <= '0;
         change_pulse <= '0;
      end else begin
         for (int i = 0; i < N; i++) cnt_q[i] <= cnt_d[i];
         stable_q     <= stable_d;
         change_pulse <= chg_d;
      end
   end

   // Strobe write, reload while strobed, serial reads with 1-fill once exhausted.
   always_comb begin
      strobe_d = strobe_q;
      dout_d   = dout;
      for (int p = 0; p < NUM_PADS; p++) sh_d[p] = sh_q[p];

      if (wr_strobe) strobe_d = din[0];

      // Reload uses the registered strobe, so a new strobe takes effect next cycle.
      if (strobe_q) begin
         for (int p = 0; p < NUM_PADS; p++) sh_d[p] = stable_q[p*BTN_W +: BTN_W];
      end

      if (rd_ok) begin
         for (int p = 0; p < NUM_PADS; p++) begin
            if (offset == 16'(p)) begin
               dout_d = {7'b0, sh_q[p][0]};
               if (!strobe_q) sh_d[p] = {1'b1, sh_q[p][BTN_W-1:1]};
            end
         end
         // $4017 without a second pad reads as zero and touches nothing else.
         if ((NUM_PADS == 1) && (offset == 16'd1)) dout_d = 8'h00;
      end
   end

   // Register interface state.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         strobe_q <= 1'b0;
         dout     <= 8'h00;
         for (int p = 0; p < NUM_PADS; p++) sh_q[p] <= '0;
      end else begin
         strobe_q <= strobe_d;
         dout     <= dout_d;
         for (int p = 0; p < NUM_PADS; p++) sh_q[p] <= sh_d[p];
      end
   end

endmodule

// File: doc/joypad_mmr_ctrl.md
# joypad_mmr_ctrl

Parametrised multi-pad joypad front end for the NES core. It synchronises and debounces up to NUM_PADS raw button arrays and flags per-pad state changes. It also implements the $4016/$4017 strobe-and-serial-read register interface, including continuous reload while the strobe is held high. It sits between the board button pins and the CPU memory-mapped I/O decode.

## Interface
Parameters:
- NUM_PADS, 2, number of pads served (1 or 2)
- BTN_W, 8, buttons per pad; bit order A, B, SELECT, START, UP, DOWN, LEFT, RIGHT (bit 0 = A)
- DEB_BITS, 21, debounce counter width; input must be stable for 2^DEB_BITS cycles
- SYNC_STAGES, 2, input synchroniser depth (>=2)
- BASE_ADDR, 16'h4016, pad 0 register; pad p is at BASE_ADDR+p

Ports:
- clk  in  1  system clock; everything is on its rising edge
- reset  in  1  asynchronous, active-low reset
- pad_in  in  NUM_PADS*BTN_W  raw, asynchronous, active-high buttons; pad p occupies [p*BTN_W +: BTN_W]
- addr  in  16  CPU address
- wr_en  in  1  single-cycle write qualifier
- rd_en  in  1  single-cycle read qualifier
- din  in  8  write data; only din[0] is used
- dout  out  8  registered read data
- pad_level  out  NUM_PADS*BTN_W  debounced button levels
- change_pulse  out  NUM_PADS  one-cycle pulse when any debounced bit of pad p changes

## Operation
- **Synchroniser.** Each pad_in bit passes through SYNC_STAGES flops before it reaches the debouncer.
- **Debounce (per bit).**
  - When synced != stable, the counter increments. When it reaches all-ones with the mismatch still present, stable <= synced and the counter clears.
  - When synced == stable, the counter clears.
  - pad_level = stable.
- **change_pulse[p].** Asserted for one cycle when pad p's stable vector differs from its value on the previous cycle.
- **Strobe register.** A write (wr_en) to BASE_ADDR sets strobe_q <= din[0]. Writes to BASE_ADDR+1 are ignored; they belong to the APU frame counter.
- **Shift registers (one per pad, BTN_W bits).**
  - While strobe_q=1, each shift register reloads from pad_level every cycle.
  - After strobe_q falls 1->0, the last loaded value is held.
- **Reads.** A read (rd_en) at BASE_ADDR+p, p<NUM_PADS:
  - dout <= {7'b0, sh[p][0]}.
  - If strobe_q=0, sh[p] <= {1'b1, sh[p][BTN_W-1:1]}. After BTN_W reads, every further read returns 1.
  - If strobe_q=1, no shift occurs; reads keep returning the live A button.
- **Unserved pad address.** A read at BASE_ADDR+1 when NUM_PADS=1 gives dout <= 8'h00 and causes no state change.
- **Non-matching addresses.** Reads to any other address leave dout unchanged. Writes to any other address are ignored.
- **Simultaneous wr_en and rd_en.** The write executes; the read is ignored.
- **Write and shift in the same cycle.** A write of 1 to strobe takes effect the next cycle; reload starts from that cycle.

## Timing
- **Reset values.** Asynchronous assertion clears everything: dout=8'h00, pad_level=0, change_pulse=0, strobe_q=0, shift registers=0, counters=0, synchronisers=0. Release is synchronous to clk.
- **Input to pad_level.** A clean input edge appears on pad_level SYNC_STAGES + 2^DEB_BITS cycles later.
- **Glitch rejection.** Any glitch shorter than 2^DEB_BITS cycles is rejected, because the counter restarts.
- **change_pulse.** Asserted the same cycle pad_level updates; width is exactly 1 cycle.
- **dout latency.** dout is valid 1 cycle after rd_en and holds until the next decoded read.
- **Shift latency.** The shift takes effect on the same edge that registers dout. A back-to-back read on the next cycle returns the next button.
- **Strobe to shift register.** Loaded values reflect pad_level of the cycle before strobe_q falls.
- **Throughput.** One read per cycle per pad; there are no stalls.

## Test plan
Run all scenarios with DEB_BITS=4, SYNC_STAGES=2, NUM_PADS=2.

1. **Reset and debounce.** Hold reset low, then release; drive pad0=8'h81 steady. Expect pad_level[7:0]=8'h81 exactly 18 cycles after the edge, a single change_pulse[0], and change_pulse[1]=0.
2. **Glitch rejection.** Drive a 10-cycle pulse on pad1 bit 3. Expect pad_level unchanged and no change_pulse.
3. **Serial readout.** With pad0=8'h81: write 1 then 0 to $4016, then perform 10 reads of $4016. Expect dout[0] sequence 1,0,0,0,0,0,0,1,1,1 and dout[7:1]=0.
4. **Live A while strobed.** Write 1 to $4016 and hold it; read $4016 three times while toggling A with settled debounce. Expect each read to return the current A; no shifting occurs.
5. **Pad independence.** With pad1=8'h02: after a strobe cycle, read $4017 twice, then $4016 once. Expect 0,1 from $4017 and pad0 bit 0 from $4016; the pads shift independently.
6. **Mid-read reset and arbitration.** Assert reset mid-readout and expect all outputs 0 immediately. Issue a simultaneous wr_en and rd_en at $4016 with din=1. Expect strobe_q=1 and dout unchanged.
